// File: rtl/seg_scan_ctrl_if.sv
// Load handshake bundle for seg_scan_ctrl: BCD value offered with valid/ready.
// Digit0 occupies load_data[3:0].
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan with frame-aligned value swap.
// Define SEG_ACTIVE_LOW_EN to invert seg/dig_en for common-anode displays.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ena,
    input  logic                  i_blank_lz,
    seg_scan_ctrl_if.slave        load_if,
    output logic [6:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_dig_en,
    output logic                  o_frame_done
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int KW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(DWELL_CYCLES - 1);
    localparam logic [KW:0]   K_BLANK = (KW + 1)'(BLANK_CYCLES);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0]            SEG_POL = '1;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = '1;
`else
    localparam logic [6:0]            SEG_POL = '0;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                r_state;
    logic [DW-1:0]         r_digit;
    logic [KW-1:0]         r_k;
    logic [VW-1:0]         r_active;
    logic [VW-1:0]         r_pending;
    logic                  r_pend_vld;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_en;
    logic                  r_frame_done;

    state_t                w_nxt_state;
    logic [DW-1:0]         w_nxt_digit;
    logic [KW-1:0]         w_nxt_k;
    logic [VW-1:0]         w_nxt_active;
    logic                  w_hs;
    logic                  w_apply;
    logic [NUM_DIGITS-1:0] w_keep;
    logic                  w_seen;
    logic [3:0]            w_nib;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_dig_oh;
    logic                  w_drive;
    logic [6:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_dig_nxt;
    logic                  w_fd_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Next position is computed first; outputs register its decode (lookahead).
    always_comb begin
        w_nxt_state = S_IDLE;
        w_nxt_digit = '0;
        w_nxt_k     = '0;
        if (i_ena) begin
            if (r_state != S_IDLE) begin
                if (r_k == K_LAST) begin
                    w_nxt_digit = (r_digit == D_LAST) ? '0 : r_digit + 1'b1;
                end else begin
                    w_nxt_digit = r_digit;
                    w_nxt_k     = r_k + 1'b1;
                end
            end
            w_nxt_state = ({1'b0, w_nxt_k} < K_BLANK) ? S_BLANK : S_DRIVE;
        end
    end

    assign load_if.load_ready = ~r_pend_vld;
    assign w_hs    = load_if.load_valid & ~r_pend_vld;
    assign w_apply = r_pend_vld & ((r_state == S_IDLE) | r_frame_done);
    assign w_nxt_active = w_apply ? r_pending : r_active;

    // Scan from the top digit down; a digit stays lit once a nonzero is seen.
    always_comb begin
        w_keep = '0;
        w_seen = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_seen    = w_seen | (|w_nxt_active[4*d +: 4]);
            w_keep[d] = w_seen | ~i_blank_lz | (d == 0);
        end
    end

    always_comb begin
        w_nib    = '0;
        w_lit    = 1'b0;
        w_dig_oh = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_nxt_digit == DW'(d)) begin
                w_nib       = w_nxt_active[4*d +: 4];
                w_lit       = w_keep[d];
                w_dig_oh[d] = 1'b1;
            end
        end
        w_drive   = (w_nxt_state == S_DRIVE) & w_lit;
        w_seg_nxt = w_drive ? seg_decode(w_nib) : '0;
        w_dig_nxt = w_drive ? w_dig_oh : '0;
        w_fd_nxt  = (w_nxt_state != S_IDLE) &
                    (w_nxt_digit == D_LAST) &
                    (w_nxt_k == K_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_digit <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_digit <= w_nxt_digit;
            r_k     <= w_nxt_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_active <= w_nxt_active;
            if (w_hs) begin
                r_pending  <= load_if.load_data;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_POL;
            r_dig_en     <= DIG_POL;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt ^ SEG_POL;
            r_dig_en     <= w_dig_nxt ^ DIG_POL;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign o_seg        = r_seg;
    assign o_dig_en     = r_dig_en;
    assign o_frame_done = r_frame_done;
endmodule
